// File: rtl/ddr2_sdram_local_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ddr2_sdram_local_port_arbiter_if
// Brief    : Avalon-style local port bundle between one master and the
//            DDR2 local-port arbiter.
// Revision : 1.0
// ============================================================================
interface ddr2_sdram_local_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 24,
    parameter int SIZE_W = 2
);
    logic                  read;
    logic                  write;
    logic [ADDR_W-1:0]     address;
    logic [SIZE_W-1:0]     size;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   be;
    logic                  waitrequest;
    logic [DATA_W-1:0]     readdata;
    logic                  readdatavalid;

    modport master (
        output read, write, address, size, wdata, be,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  read, write, address, size, wdata, be,
        output waitrequest, readdata, readdatavalid
    );
endinterface
`default_nettype wire

// File: rtl/ddr2_sdram_local_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ddr2_sdram_local_port_arbiter
// Brief    : Two-port round-robin arbiter for the DDR2 controller local port,
//            with write-burst locking and an in-order read-return tag FIFO.
// Revision : 1.0
// ============================================================================
module ddr2_sdram_local_port_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 24,
    parameter int SIZE_W    = 2,
    parameter int TAG_DEPTH = 8
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    ddr2_sdram_local_port_arbiter_if.slave p0,
    ddr2_sdram_local_port_arbiter_if.slave p1,
    input  wire logic                   ctl_init_done,
    input  wire logic                   ctl_ready,
    output logic                        ctl_read_req,
    output logic                        ctl_write_req,
    output logic                        ctl_burstbegin,
    output logic [ADDR_W-1:0]           ctl_addr,
    output logic [SIZE_W-1:0]           ctl_size,
    output logic [DATA_W-1:0]           ctl_wdata,
    output logic [DATA_W/8-1:0]         ctl_be,
    input  wire logic [DATA_W-1:0]      ctl_rdata,
    input  wire logic                   ctl_rdata_valid,
    output logic                        rd_underflow
);

    localparam int c_ptr_w = $clog2(TAG_DEPTH);
    localparam logic [c_ptr_w:0]   c_depth    = (c_ptr_w+1)'(TAG_DEPTH);
    localparam logic [SIZE_W-1:0]  c_size_one = SIZE_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_WBURST = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_rr;
    logic                   r_owner;
    logic [SIZE_W-1:0]      r_remaining;
    logic [ADDR_W-1:0]      r_burst_addr;
    logic [SIZE_W-1:0]      r_burst_size;

    logic                   r_tag_port [TAG_DEPTH];
    logic [SIZE_W-1:0]      r_tag_size [TAG_DEPTH];
    logic [c_ptr_w-1:0]     r_wr_ptr;
    logic [c_ptr_w-1:0]     r_rd_ptr;
    logic [c_ptr_w:0]       r_count;
    logic [SIZE_W-1:0]      r_head_cnt;

    logic                   r_underflow;
    logic                   r_rdv0;
    logic                   r_rdv1;
    logic [DATA_W-1:0]      r_rdata0;
    logic [DATA_W-1:0]      r_rdata1;

    logic                   w_empty;
    logic                   w_full;
    logic                   w_beat;
    logic                   w_head_port;
    logic [SIZE_W-1:0]      w_head_size;
    logic                   w_head_last;
    logic                   w_pop;
    logic                   w_tag_avail;
    logic                   w_elig0;
    logic                   w_elig1;
    logic                   w_sel_valid;
    logic                   w_sel_port;
    logic                   w_is_idle;
    logic                   w_s_read;
    logic                   w_s_write;
    logic [ADDR_W-1:0]      w_s_addr;
    logic [SIZE_W-1:0]      w_s_size;
    logic [SIZE_W-1:0]      w_s_size_eff;
    logic [DATA_W-1:0]      w_s_wdata;
    logic [DATA_W/8-1:0]    w_s_be;
    logic                   w_accept;
    logic                   w_push;

    // Tag FIFO status; a pop in this cycle frees a slot for a read pushed in the same cycle
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_depth);
    assign w_beat      = ctl_rdata_valid & ~w_empty;
    assign w_head_port = r_tag_port[r_rd_ptr];
    assign w_head_size = r_tag_size[r_rd_ptr];
    assign w_head_last = (({1'b0, r_head_cnt} + 1'b1) == {1'b0, w_head_size});
    assign w_pop       = w_beat & w_head_last;
    assign w_tag_avail = ~w_full | w_pop;

    assign w_elig0   = p0.write | (p0.read & w_tag_avail);
    assign w_elig1   = p1.write | (p1.read & w_tag_avail);
    assign w_is_idle = (r_state == ST_IDLE);

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_port  = 1'b0;
        if (!reset && ctl_init_done) begin
            if (r_state == ST_WBURST) begin
                w_sel_valid = 1'b1;
                w_sel_port  = r_owner;
            end else if (w_elig0 && w_elig1) begin
                w_sel_valid = 1'b1;
                w_sel_port  = r_rr;
            end else if (w_elig0) begin
                w_sel_valid = 1'b1;
                w_sel_port  = 1'b0;
            end else if (w_elig1) begin
                w_sel_valid = 1'b1;
                w_sel_port  = 1'b1;
            end
        end
    end

    assign w_s_read     = w_sel_port ? p1.read    : p0.read;
    assign w_s_write    = w_sel_port ? p1.write   : p0.write;
    assign w_s_addr     = w_sel_port ? p1.address : p0.address;
    assign w_s_size     = w_sel_port ? p1.size    : p0.size;
    assign w_s_wdata    = w_sel_port ? p1.wdata   : p0.wdata;
    assign w_s_be       = w_sel_port ? p1.be      : p0.be;
    assign w_s_size_eff = (w_s_size == '0) ? c_size_one : w_s_size;

    // Write wins when a master illegally raises read and write together
    always_comb begin
        ctl_read_req   = w_sel_valid & w_is_idle & ~w_s_write & w_s_read;
        ctl_write_req  = w_sel_valid & w_s_write;
        ctl_burstbegin = w_sel_valid & w_is_idle;
        ctl_addr       = '0;
        ctl_size       = '0;
        ctl_wdata      = '0;
        ctl_be         = '0;
        if (w_sel_valid) begin
            ctl_addr  = w_is_idle ? w_s_addr     : r_burst_addr;
            ctl_size  = w_is_idle ? w_s_size_eff : r_burst_size;
            ctl_wdata = w_s_wdata;
            ctl_be    = w_s_be;
        end
    end

    assign w_accept = (ctl_read_req | ctl_write_req) & ctl_ready;
    assign w_push   = ctl_read_req & ctl_ready;

    assign p0.waitrequest   = ~(w_sel_valid & ~w_sel_port & ctl_ready);
    assign p1.waitrequest   = ~(w_sel_valid &  w_sel_port & ctl_ready);
    assign p0.readdatavalid = r_rdv0;
    assign p1.readdatavalid = r_rdv1;
    assign p0.readdata      = r_rdata0;
    assign p1.readdata      = r_rdata1;
    assign rd_underflow     = r_underflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_s_write && (w_s_size_eff > c_size_one)) begin
                    w_state_nxt = ST_WBURST;
                end
            end
            ST_WBURST: begin
                if (w_accept && (r_remaining == c_size_one)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr         <= 1'b0;
            r_owner      <= 1'b0;
            r_remaining  <= '0;
            r_burst_addr <= '0;
            r_burst_size <= '0;
        end else if (w_accept) begin
            r_rr <= ~w_sel_port;
            if (w_is_idle) begin
                r_owner      <= w_sel_port;
                r_remaining  <= w_s_size_eff - c_size_one;
                r_burst_addr <= w_s_addr;
                r_burst_size <= w_s_size_eff;
            end else begin
                r_remaining  <= r_remaining - c_size_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag_port[r_wr_ptr] <= w_sel_port;
            r_tag_size[r_wr_ptr] <= w_s_size_eff;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_head_cnt  <= '0;
            r_underflow <= 1'b0;
            r_rdv0      <= 1'b0;
            r_rdv1      <= 1'b0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_beat) begin
                r_head_cnt <= w_head_last ? '0 : (r_head_cnt + 1'b1);
            end
            if (ctl_rdata_valid && w_empty) begin
                r_underflow <= 1'b1;
            end
            r_rdv0 <= w_beat & ~w_head_port;
            r_rdv1 <= w_beat &  w_head_port;
            if (w_beat && !w_head_port) begin
                r_rdata0 <= ctl_rdata;
            end
            if (w_beat && w_head_port) begin
                r_rdata1 <= ctl_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr2_sdram_local_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr2_sdram_local_port_arbiter
// Brief    : Directed scenarios plus randomized traffic against a queue-based
//            reference model of the two-port local arbiter.
// Revision : 1.0
// ============================================================================
module tb_ddr2_sdram_local_port_arbiter;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 24;
    localparam int SIZE_W    = 2;
    localparam int TAG_DEPTH = 8;
    localparam int BE_W      = DATA_W / 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ddr2_sdram_local_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W)) p0_if ();
    ddr2_sdram_local_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W)) p1_if ();

    logic               ctl_init_done;
    logic               ctl_ready;
    logic               ctl_read_req;
    logic               ctl_write_req;
    logic               ctl_burstbegin;
    logic [ADDR_W-1:0]  ctl_addr;
    logic [SIZE_W-1:0]  ctl_size;
    logic [DATA_W-1:0]  ctl_wdata;
    logic [BE_W-1:0]    ctl_be;
    logic [DATA_W-1:0]  ctl_rdata;
    logic               ctl_rdata_valid;
    logic               rd_underflow;

    int n_checks = 0;
    int n_fail   = 0;

    ddr2_sdram_local_port_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .p0(p0_if), .p1(p1_if),
        .ctl_init_done(ctl_init_done), .ctl_ready(ctl_ready),
        .ctl_read_req(ctl_read_req), .ctl_write_req(ctl_write_req),
        .ctl_burstbegin(ctl_burstbegin), .ctl_addr(ctl_addr), .ctl_size(ctl_size),
        .ctl_wdata(ctl_wdata), .ctl_be(ctl_be), .ctl_rdata(ctl_rdata),
        .ctl_rdata_valid(ctl_rdata_valid), .rd_underflow(rd_underflow)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_port(input int p, input logic rd, input logic wr,
                              input logic [ADDR_W-1:0] addr, input logic [SIZE_W-1:0] sz,
                              input logic [DATA_W-1:0] wd, input logic [BE_W-1:0] be);
        if (p == 0) begin
            p0_if.read = rd; p0_if.write = wr; p0_if.address = addr;
            p0_if.size = sz; p0_if.wdata = wd; p0_if.be = be;
        end else begin
            p1_if.read = rd; p1_if.write = wr; p1_if.address = addr;
            p1_if.size = sz; p1_if.wdata = wd; p1_if.be = be;
        end
    endtask

    task automatic idle_inputs();
        drive_port(0, 1'b0, 1'b0, '0, '0, '0, '0);
        drive_port(1, 1'b0, 1'b0, '0, '0, '0, '0);
        ctl_ready       = 1'b1;
        ctl_rdata_valid = 1'b0;
        ctl_rdata       = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        ctl_init_done = 1'b1;
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] got;
        idle_inputs();
        ctl_init_done = 1'b0;
        reset = 1'b1;
        cyc();
        cyc();
        #1;
        got = {ctl_read_req, ctl_write_req, ctl_burstbegin, p0_if.waitrequest,
               p1_if.waitrequest, p0_if.readdatavalid, p1_if.readdatavalid};
        n_checks++;
        if (got !== 7'b0001100) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected %b", got, 7'b0001100);
        end
        n_checks++;
        if ({p0_if.readdata, p1_if.readdata, rd_underflow} !== '0) begin
            n_fail++; $display("FAIL reset_rdata: got %h %h uf=%b expected zeros",
                               p0_if.readdata, p1_if.readdata, rd_underflow);
        end
        reset = 1'b0;
        drive_port(0, 1'b0, 1'b1, 24'h000010, 2'd1, 32'h12345678, '1);
        drive_port(1, 1'b1, 1'b0, 24'h000020, 2'd1, '0, '1);
        #1;
        got = {ctl_read_req, ctl_write_req, ctl_burstbegin, p0_if.waitrequest,
               p1_if.waitrequest, 2'b00};
        n_checks++;
        if (got !== 7'b0001100) begin
            n_fail++; $display("FAIL pre_init_gate: got %b expected %b", got, 7'b0001100);
        end
        cyc();
        ctl_init_done = 1'b1;
    endtask

    task automatic test_single_read();
        do_reset();
        drive_port(0, 1'b1, 1'b0, 24'h000100, 2'd1, '0, '1);
        #1;
        n_checks++;
        if ({ctl_read_req, ctl_write_req, ctl_burstbegin, ctl_addr, p0_if.waitrequest, p1_if.waitrequest}
            !== {3'b101, 24'h000100, 2'b01}) begin
            n_fail++; $display("FAIL single_read_cmd: got rd=%b wr=%b bb=%b addr=%h wr0=%b wr1=%b expected 1 0 1 000100 0 1",
                               ctl_read_req, ctl_write_req, ctl_burstbegin, ctl_addr,
                               p0_if.waitrequest, p1_if.waitrequest);
        end
        cyc();
        drive_port(0, 1'b0, 1'b0, '0, '0, '0, '0);
        ctl_rdata_valid = 1'b1;
        ctl_rdata = 32'hDEADBEEF;
        #1;
        n_checks++;
        if (ctl_read_req !== 1'b0) begin
            n_fail++; $display("FAIL single_read_one_cycle: got %b expected 0", ctl_read_req);
        end
        cyc();
        ctl_rdata_valid = 1'b0;
        n_checks++;
        if ({p0_if.readdatavalid, p1_if.readdatavalid, p0_if.readdata} !== {2'b10, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL single_read_return: got v0=%b v1=%b d=%h expected 1 0 deadbeef",
                               p0_if.readdatavalid, p1_if.readdatavalid, p0_if.readdata);
        end
        cyc();
        n_checks++;
        if (p0_if.readdatavalid !== 1'b0) begin
            n_fail++; $display("FAIL single_read_pulse: got %b expected 0", p0_if.readdatavalid);
        end
    endtask

    task automatic test_contention();
        int g;
        logic [DATA_W-1:0] exp_d;
        do_reset();
        drive_port(0, 1'b0, 1'b1, 24'h000A00, 2'd1, 32'hA0A0A0A0, '1);
        drive_port(1, 1'b0, 1'b1, 24'h000B00, 2'd0, 32'hB1B1B1B1, '1);
        for (int i = 0; i < 6; i++) begin
            #1;
            g = i % 2;
            exp_d = (g == 0) ? 32'hA0A0A0A0 : 32'hB1B1B1B1;
            n_checks++;
            if ({ctl_write_req, ctl_wdata, p0_if.waitrequest, p1_if.waitrequest}
                !== {1'b1, exp_d, (g != 0), (g != 1)}) begin
                n_fail++; $display("FAIL contention_grant %0d: got wdata=%h wr0=%b wr1=%b expected grant p%0d",
                                   i, ctl_wdata, p0_if.waitrequest, p1_if.waitrequest, g);
            end
            cyc();
        end
        idle_inputs();
    endtask

    task automatic test_burst_lock();
        do_reset();
        drive_port(0, 1'b0, 1'b1, 24'h000050, 2'd1, 32'h0, '1);
        cyc();
        drive_port(0, 1'b1, 1'b0, 24'h000300, 2'd1, '0, '1);
        drive_port(1, 1'b0, 1'b1, 24'h000200, 2'd2, 32'h11111111, '1);
        #1;
        n_checks++;
        if ({ctl_write_req, ctl_burstbegin, ctl_addr, ctl_size, ctl_wdata, p0_if.waitrequest, p1_if.waitrequest}
            !== {2'b11, 24'h000200, 2'd2, 32'h11111111, 2'b10}) begin
            n_fail++; $display("FAIL burst_beat0: got wr=%b bb=%b addr=%h size=%0d d=%h wr0=%b wr1=%b",
                               ctl_write_req, ctl_burstbegin, ctl_addr, ctl_size, ctl_wdata,
                               p0_if.waitrequest, p1_if.waitrequest);
        end
        cyc();
        drive_port(1, 1'b0, 1'b1, 24'h0003FF, 2'd2, 32'h22222222, '1);
        #1;
        n_checks++;
        if ({ctl_read_req, ctl_write_req, ctl_burstbegin, ctl_addr, ctl_wdata, p0_if.waitrequest, p1_if.waitrequest}
            !== {3'b010, 24'h000200, 32'h22222222, 2'b10}) begin
            n_fail++; $display("FAIL burst_beat1: got rd=%b wr=%b bb=%b addr=%h d=%h wr0=%b wr1=%b",
                               ctl_read_req, ctl_write_req, ctl_burstbegin, ctl_addr, ctl_wdata,
                               p0_if.waitrequest, p1_if.waitrequest);
        end
        cyc();
        drive_port(1, 1'b0, 1'b0, '0, '0, '0, '0);
        #1;
        n_checks++;
        if ({ctl_read_req, ctl_burstbegin, ctl_addr, p0_if.waitrequest} !== {2'b11, 24'h000300, 1'b0}) begin
            n_fail++; $display("FAIL burst_then_read: got rd=%b bb=%b addr=%h wr0=%b expected 1 1 000300 0",
                               ctl_read_req, ctl_burstbegin, ctl_addr, p0_if.waitrequest);
        end
        cyc();
        idle_inputs();
    endtask

    task automatic test_ordering();
        logic [DATA_W-1:0] beats [3];
        int exp_port [3] = '{0, 0, 1};
        logic [DATA_W-1:0] got_d;
        for (int i = 0; i < 3; i++) beats[i] = $urandom;
        do_reset();
        drive_port(0, 1'b1, 1'b0, 24'h000010, 2'd2, '0, '1);
        cyc();
        drive_port(0, 1'b0, 1'b0, '0, '0, '0, '0);
        drive_port(1, 1'b1, 1'b0, 24'h000020, 2'd1, '0, '1);
        #1;
        n_checks++;
        if ({ctl_read_req, ctl_size, p1_if.waitrequest} !== {1'b1, 2'd1, 1'b0}) begin
            n_fail++; $display("FAIL order_p1_read: got rd=%b size=%0d wr1=%b expected 1 1 0",
                               ctl_read_req, ctl_size, p1_if.waitrequest);
        end
        cyc();
        drive_port(1, 1'b0, 1'b0, '0, '0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            ctl_rdata_valid = 1'b1;
            ctl_rdata = beats[i];
            cyc();
            got_d = (exp_port[i] == 0) ? p0_if.readdata : p1_if.readdata;
            n_checks++;
            if ({p0_if.readdatavalid, p1_if.readdatavalid, got_d}
                !== {(exp_port[i] == 0), (exp_port[i] == 1), beats[i]}) begin
                n_fail++; $display("FAIL order_beat%0d: got v0=%b v1=%b d=%h expected port %0d d=%h",
                                   i, p0_if.readdatavalid, p1_if.readdatavalid, got_d, exp_port[i], beats[i]);
            end
        end
        ctl_rdata = 32'h55555555;
        cyc();
        ctl_rdata_valid = 1'b0;
        n_checks++;
        if ({rd_underflow, p0_if.readdatavalid, p1_if.readdatavalid} !== 3'b100) begin
            n_fail++; $display("FAIL order_fifo_empty: got uf=%b v0=%b v1=%b expected 1 0 0",
                               rd_underflow, p0_if.readdatavalid, p1_if.readdatavalid);
        end
    endtask

    task automatic test_fifo_full();
        do_reset();
        drive_port(0, 1'b1, 1'b0, 24'h000400, 2'd1, '0, '1);
        for (int i = 0; i < TAG_DEPTH; i++) begin
            #1;
            n_checks++;
            if (p0_if.waitrequest !== 1'b0) begin
                n_fail++; $display("FAIL fill_read%0d: got waitrequest %b expected 0", i, p0_if.waitrequest);
            end
            cyc();
        end
        drive_port(1, 1'b0, 1'b1, 24'h000500, 2'd1, 32'hCAFEF00D, '1);
        #1;
        n_checks++;
        if ({p0_if.waitrequest, p1_if.waitrequest, ctl_read_req, ctl_write_req} !== 4'b1001) begin
            n_fail++; $display("FAIL full_write_passes: got wr0=%b wr1=%b rd=%b wr=%b expected 1 0 0 1",
                               p0_if.waitrequest, p1_if.waitrequest, ctl_read_req, ctl_write_req);
        end
        cyc();
        drive_port(1, 1'b0, 1'b0, '0, '0, '0, '0);
        #1;
        n_checks++;
        if ({p0_if.waitrequest, ctl_read_req} !== 2'b10) begin
            n_fail++; $display("FAIL full_read_blocked: got wr0=%b rd=%b expected 1 0",
                               p0_if.waitrequest, ctl_read_req);
        end
        ctl_rdata_valid = 1'b1;
        ctl_rdata = 32'h0BADF00D;
        #1;
        n_checks++;
        if ({p0_if.waitrequest, ctl_read_req} !== 2'b01) begin
            n_fail++; $display("FAIL full_push_with_pop: got wr0=%b rd=%b expected 0 1",
                               p0_if.waitrequest, ctl_read_req);
        end
        cyc();
        idle_inputs();
        n_checks++;
        if ({p0_if.readdatavalid, p0_if.readdata} !== {1'b1, 32'h0BADF00D}) begin
            n_fail++; $display("FAIL full_pop_return: got v0=%b d=%h expected 1 0badf00d",
                               p0_if.readdatavalid, p0_if.readdata);
        end
    endtask

    task automatic test_underflow_reset();
        do_reset();
        ctl_rdata_valid = 1'b1;
        ctl_rdata = 32'h77777777;
        cyc();
        ctl_rdata_valid = 1'b0;
        n_checks++;
        if ({rd_underflow, p0_if.readdatavalid, p1_if.readdatavalid} !== 3'b100) begin
            n_fail++; $display("FAIL underflow_set: got uf=%b v0=%b v1=%b expected 1 0 0",
                               rd_underflow, p0_if.readdatavalid, p1_if.readdatavalid);
        end
        drive_port(0, 1'b0, 1'b1, 24'h000600, 2'd3, 32'h1, '1);
        cyc();
        drive_port(0, 1'b0, 1'b0, '0, '0, '0, '0);
        cyc();
        n_checks++;
        if (rd_underflow !== 1'b1) begin
            n_fail++; $display("FAIL underflow_sticky: got %b expected 1", rd_underflow);
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        n_checks++;
        if ({rd_underflow, p0_if.readdatavalid, p1_if.readdatavalid, p0_if.readdata} !== '0) begin
            n_fail++; $display("FAIL underflow_cleared: got uf=%b v0=%b v1=%b d0=%h expected zeros",
                               rd_underflow, p0_if.readdatavalid, p1_if.readdatavalid, p0_if.readdata);
        end
        drive_port(1, 1'b0, 1'b1, 24'h000700, 2'd1, 32'h2, '1);
        #1;
        n_checks++;
        if ({ctl_write_req, ctl_burstbegin, ctl_addr, p1_if.waitrequest} !== {2'b11, 24'h000700, 1'b0}) begin
            n_fail++; $display("FAIL burst_discarded: got wr=%b bb=%b addr=%h wr1=%b expected 1 1 000700 0",
                               ctl_write_req, ctl_burstbegin, ctl_addr, p1_if.waitrequest);
        end
        cyc();
        idle_inputs();
    endtask

    task automatic test_random();
        int m_rr, m_owner, m_left, m_sel, cmds, exp_size;
        logic [ADDR_W-1:0] m_baddr, exp_addr;
        int port_q[$];
        bit last_q[$];
        bit m_uf;
        bit e_rdv [2];
        logic [DATA_W-1:0] e_rdata [2];
        logic w [2];
        logic r [2];
        logic [ADDR_W-1:0] a [2];
        int s [2];
        logic [DATA_W-1:0] d [2];
        logic [BE_W-1:0] b [2];
        bit pop_now, tag_ok, e0, e1, exp_rd, exp_wr, exp_bb, ready;
        logic [4:0] got, expv;
        do_reset();
        m_rr = 0; m_owner = 0; m_left = 0; cmds = 0; m_baddr = '0; m_uf = 1'b0;
        e_rdv = '{1'b0, 1'b0};
        e_rdata = '{'0, '0};
        for (int i = 0; i < 3000; i++) begin
            for (int p = 0; p < 2; p++) begin
                w[p] = ($urandom_range(0, 99) < 35);
                r[p] = !w[p] && ($urandom_range(0, 99) < 45);
                if ($urandom_range(0, 99) < 2) r[p] = 1'b1;
                a[p] = ADDR_W'($urandom);
                s[p] = $urandom_range(0, 3);
                d[p] = $urandom;
                b[p] = BE_W'($urandom);
                drive_port(p, r[p], w[p], a[p], SIZE_W'(s[p]), d[p], b[p]);
            end
            ctl_init_done   = (i >= 8);
            ready           = ($urandom_range(0, 99) < 70);
            ctl_ready       = ready;
            ctl_rdata_valid = (port_q.size() > 0) && ($urandom_range(0, 99) < 40);
            ctl_rdata       = $urandom;
            #1;
            pop_now = ctl_rdata_valid && (port_q.size() > 0) && last_q[0];
            tag_ok  = (cmds < TAG_DEPTH) || pop_now;
            m_sel = -1; exp_rd = 0; exp_wr = 0; exp_bb = 0; exp_addr = '0; exp_size = 0;
            if (ctl_init_done) begin
                if (m_left > 0) begin
                    m_sel = m_owner; exp_wr = w[m_sel]; exp_addr = m_baddr;
                end else begin
                    e0 = w[0] || (r[0] && tag_ok);
                    e1 = w[1] || (r[1] && tag_ok);
                    if (e0 && e1) m_sel = m_rr;
                    else if (e0) m_sel = 0;
                    else if (e1) m_sel = 1;
                    if (m_sel >= 0) begin
                        exp_wr = w[m_sel]; exp_rd = !w[m_sel]; exp_bb = 1;
                        exp_addr = a[m_sel]; exp_size = (s[m_sel] == 0) ? 1 : s[m_sel];
                    end
                end
            end
            expv = {exp_rd, exp_wr, exp_bb, !(m_sel == 0 && ready), !(m_sel == 1 && ready)};
            got  = {ctl_read_req, ctl_write_req, ctl_burstbegin, p0_if.waitrequest, p1_if.waitrequest};
            n_checks++;
            if (got !== expv) begin
                n_fail++; $display("FAIL rand_cmd cycle %0d: got %b expected %b", i, got, expv);
            end
            if (exp_rd || exp_wr) begin
                n_checks++;
                if (ctl_addr !== exp_addr) begin
                    n_fail++; $display("FAIL rand_addr cycle %0d: got %h expected %h", i, ctl_addr, exp_addr);
                end
            end
            if (exp_bb) begin
                n_checks++;
                if (ctl_size !== SIZE_W'(exp_size)) begin
                    n_fail++; $display("FAIL rand_size cycle %0d: got %0d expected %0d", i, ctl_size, exp_size);
                end
            end
            if (exp_wr) begin
                n_checks++;
                if ({ctl_wdata, ctl_be} !== {d[m_sel], b[m_sel]}) begin
                    n_fail++; $display("FAIL rand_wdata cycle %0d: got %h/%h expected %h/%h",
                                       i, ctl_wdata, ctl_be, d[m_sel], b[m_sel]);
                end
            end
            n_checks++;
            if ({p0_if.readdatavalid, p1_if.readdatavalid, rd_underflow} !== {e_rdv[0], e_rdv[1], m_uf}) begin
                n_fail++; $display("FAIL rand_rvalid cycle %0d: got %b%b uf=%b expected %b%b uf=%b", i,
                                   p0_if.readdatavalid, p1_if.readdatavalid, rd_underflow, e_rdv[0], e_rdv[1], m_uf);
            end
            for (int p = 0; p < 2; p++) begin
                if (e_rdv[p]) begin
                    n_checks++;
                    if (((p == 0) ? p0_if.readdata : p1_if.readdata) !== e_rdata[p]) begin
                        n_fail++; $display("FAIL rand_rdata p%0d cycle %0d: got %h expected %h", p, i,
                                           (p == 0) ? p0_if.readdata : p1_if.readdata, e_rdata[p]);
                    end
                end
            end
            e_rdv = '{1'b0, 1'b0};
            if (ctl_rdata_valid) begin
                if (port_q.size() == 0) begin
                    m_uf = 1'b1;
                end else begin
                    int pp;
                    pp = port_q.pop_front();
                    if (last_q.pop_front()) cmds--;
                    e_rdv[pp] = 1'b1;
                    e_rdata[pp] = ctl_rdata;
                end
            end
            if ((exp_rd || exp_wr) && ready) begin
                m_rr = 1 - m_sel;
                if (exp_rd) begin
                    for (int k = 0; k < exp_size; k++) begin
                        port_q.push_back(m_sel);
                        last_q.push_back(k == exp_size - 1);
                    end
                    cmds++;
                end else if (m_left > 0) begin
                    m_left--;
                end else if (exp_size > 1) begin
                    m_left = exp_size - 1; m_owner = m_sel; m_baddr = exp_addr;
                end
            end
            cyc();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        ctl_init_done = 1'b0;
        test_reset();
        test_single_read();
        test_contention();
        test_burst_lock();
        test_ordering();
        test_fifo_full();
        test_underflow_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
